// File: rtl/qspi_boot_loader.sv
// Boot-time copier: reads WORDS 32-bit words from SPI flash (READ 0x03, single-bit
// mode 0) and writes them to TCM, then releases the core reset.
module qspi_boot_loader #(
    parameter int          TCM_AWIDTH = 15,
    parameter int          WORDS      = 16,
    parameter logic [23:0] FLASH_ADDR = 24'h40_0000,
    parameter int          SCK_DIV    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  boot_skip_i,
    output logic                  io_qspi_sck_o,
    output logic                  io_qspi_cs_0_o,
    output logic [3:0]            io_qspi_dq_o,
    output logic [3:0]            io_qspi_dq_oe,
    input  logic [3:0]            io_qspi_dq_i,
    output logic                  tcm_we_o,
    output logic [TCM_AWIDTH-3:0] tcm_addr_o,
    output logic [31:0]           tcm_wdata_o,
    input  logic                  tcm_gnt_i,
    output logic                  done_o,
    output logic                  core_rst_n_o
);
    localparam int CW = TCM_AWIDTH - 1;
    localparam int DW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam logic [CW-1:0] WORDS_LAST = CW'(WORDS - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(SCK_DIV - 1);
    localparam logic [7:0]    CMD_READ   = 8'h03;

    typedef enum logic [2:0] {IDLE, CS_SETUP, CMD, ADDR, DATA, WRITE, CS_HOLD, DONE} state_t;

    state_t                state;
    logic [DW-1:0]         div_cnt;
    logic [4:0]            bit_cnt;
    logic [CW-1:0]         word_cnt;
    logic [31:0]           tx_sh;
    logic [31:0]           rx_sh;
    logic                  sck, cs_n, mosi, busy, we, done;
    logic [TCM_AWIDTH-3:0] addr;
    logic [31:0]           wdata;

    logic div_end;
    assign div_end = (div_cnt == DIV_LAST);

    logic unused_dq;
    assign unused_dq = ^{io_qspi_dq_i[3:2], io_qspi_dq_i[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            sck      <= 1'b0;
            cs_n     <= 1'b1;
            mosi     <= 1'b0;
            busy     <= 1'b0;
            we       <= 1'b0;
            done     <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (boot_skip_i || WORDS == 0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state   <= CS_SETUP;
                        cs_n    <= 1'b0;
                        busy    <= 1'b1;
                        tx_sh   <= {CMD_READ, FLASH_ADDR};
                        div_cnt <= '0;
                    end
                end
                CS_SETUP: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= CMD;
                        mosi    <= tx_sh[31];
                        tx_sh   <= {tx_sh[30:0], 1'b0};
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                // Command and address share one 32-bit shifter; MOSI moves only as sck falls.
                CMD, ADDR: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        sck     <= ~sck;
                        if (sck) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            mosi    <= tx_sh[31];
                            tx_sh   <= {tx_sh[30:0], 1'b0};
                            if (bit_cnt == 5'd7) state <= ADDR;
                            if (bit_cnt == 5'd31) begin
                                state <= DATA;
                                mosi  <= 1'b0;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        sck     <= ~sck;
                        if (!sck) begin
                            rx_sh <= {rx_sh[30:0], io_qspi_dq_i[1]};
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 5'd31) begin
                                state <= WRITE;
                                we    <= 1'b1;
                                // first byte on the wire is the least significant
                                wdata <= {rx_sh[7:0], rx_sh[15:8], rx_sh[23:16], rx_sh[31:24]};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (tcm_gnt_i) begin
                        we       <= 1'b0;
                        addr     <= addr + 1'b1;
                        word_cnt <= word_cnt + 1'b1;
                        div_cnt  <= '0;
                        state    <= (word_cnt == WORDS_LAST) ? CS_HOLD : DATA;
                    end
                end
                CS_HOLD: begin
                    if (div_end) begin
                        state <= DONE;
                        cs_n  <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DONE: state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    assign io_qspi_sck_o  = sck;
    assign io_qspi_cs_0_o = cs_n;
    assign io_qspi_dq_o   = {3'b000, mosi};
    assign io_qspi_dq_oe  = {3'b000, busy};
    assign tcm_we_o       = we;
    assign tcm_addr_o     = addr;
    assign tcm_wdata_o    = wdata;
    assign done_o         = done;
    assign core_rst_n_o   = done;
endmodule
